// File: rtl/alu_op_issue_if.sv
// Bundles the command, ALU-side and result signals of the ALU command front-end.
// slave is the issue unit's view and master is the surrounding environment's view.
interface alu_op_issue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             CMD_VALID;
  logic             CMD_READY;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_B;
  logic [3:0]       CMD_FUN;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [3:0]       ALU_FUN;
  logic             ALU_GO;
  logic [WIDTH-1:0] ALU_OUT;
  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES_DATA;
  logic [1:0]       RES_CLASS;
  logic [CW-1:0]    FIFO_COUNT;

  modport slave (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN, ALU_OUT, RES_READY,
    output CMD_READY, ALU_A, ALU_B, ALU_FUN, ALU_GO,
    output RES_VALID, RES_DATA, RES_CLASS, FIFO_COUNT
  );

  modport master (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN, ALU_OUT, RES_READY,
    input  CMD_READY, ALU_A, ALU_B, ALU_FUN, ALU_GO,
    input  RES_VALID, RES_DATA, RES_CLASS, FIFO_COUNT
  );
endinterface

// File: rtl/alu_op_issue.sv
// Command FIFO plus a one-at-a-time issue FSM in front of the ALU.
// Each result is captured and then held until the downstream stage takes it.
module alu_op_issue #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic           CLK,
  input  logic           RST,
  alu_op_issue_if.slave  bus,
  output logic [1:0]     dbg_state_o
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH + 4;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  state_e           state_q, state_d;
  logic [LW-1:0]    wait_q, wait_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, res_data_q;
  logic [3:0]       alu_fun_q;
  logic [1:0]       res_class_q;
  logic             alu_go_q, res_valid_q;

  logic             cmd_ready, push, load, capture, release_res;
  logic [EW-1:0]    head;

  // Handshakes: a command moves on CMD_VALID && CMD_READY; a result moves on
  // RES_VALID && RES_READY, and RES_VALID with its data stays put until then.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = bus.CMD_VALID && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    load        = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = LW'(ALU_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end else begin
          wait_d = wait_q - LW'(1);
        end
      end
      S_HOLD: begin
        if (bus.RES_READY) begin
          release_res = 1'b1;
          // Chain straight into the next issue so there is no idle bubble.
          if (count_q != '0) begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {bus.CMD_A, bus.CMD_B, bus.CMD_FUN};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      wait_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_go_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_class_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      alu_go_q <= load;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, load})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (load) begin
        alu_a_q   <= head[EW-1 -: WIDTH];
        alu_b_q   <= head[WIDTH+3 -: WIDTH];
        alu_fun_q <= head[3:0];
      end
      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= bus.ALU_OUT;
        res_class_q <= alu_fun_q[3:2];
      end else if (release_res) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.ALU_A      = alu_a_q;
  assign bus.ALU_B      = alu_b_q;
  assign bus.ALU_FUN    = alu_fun_q;
  assign bus.ALU_GO     = alu_go_q;
  assign bus.RES_VALID  = res_valid_q;
  assign bus.RES_DATA   = res_data_q;
  assign bus.RES_CLASS  = res_class_q;
  assign bus.FIFO_COUNT = count_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: a queue-based model checked every cycle plus directed literal checks.
// A second instance built with ALU_LAT=3 covers the longer-latency case.
module tb_alu_op_issue;
  localparam int W    = 16;
  localparam int D    = 4;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_issue_if #(.WIDTH(W), .DEPTH(D)) bus1 ();
  alu_op_issue_if #(.WIDTH(W), .DEPTH(D)) bus3 ();
  logic [1:0] dbg1, dbg3;

  alu_op_issue #(.WIDTH(W), .DEPTH(D), .ALU_LAT(LAT)) dut (
    .CLK(clk), .RST(rst), .bus(bus1), .dbg_state_o(dbg1));
  alu_op_issue #(.WIDTH(W), .DEPTH(D), .ALU_LAT(LAT3)) dut3 (
    .CLK(clk), .RST(rst), .bus(bus3), .dbg_state_o(dbg3));

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   fun;
  } cmd_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_fn(input cmd_t c);
    case (c.fun[3:2])
      2'b00: return c.fun[0] ? c.a - c.b : c.a + c.b;
      2'b01: begin
        case (c.fun[1:0])
          2'b00:   return c.a & c.b;
          2'b01:   return c.a | c.b;
          2'b10:   return c.a ^ c.b;
          default: return ~c.a;
        endcase
      end
      2'b10:   return (c.a < c.b) ? W'(1) : W'(0);
      default: return c.a << c.b[3:0];
    endcase
  endfunction

  // ALU stand-ins: the result is only present on the cycle the latency says, junk otherwise.
  logic [W-1:0] alu1_q;
  logic [W-1:0] alu3_q [LAT3];
  always @(posedge clk) begin
    alu1_q <= bus1.ALU_GO ? alu_fn({bus1.ALU_A, bus1.ALU_B, bus1.ALU_FUN})
                          : (W'(cyc) ^ W'(16'hA5A5));
    alu3_q[0] <= bus3.ALU_GO ? alu_fn({bus3.ALU_A, bus3.ALU_B, bus3.ALU_FUN})
                             : (W'(cyc) ^ W'(16'h5A5A));
    for (int i = 1; i < LAT3; i++) alu3_q[i] <= alu3_q[i-1];
  end
  assign bus1.ALU_OUT = alu1_q;
  assign bus3.ALU_OUT = alu3_q[LAT3-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: pending commands in a queue, the unit as a phase since its last load
  // (-1 idle, 0 issue, 1..LAT waiting, LAT+1 holding a result).
  cmd_t             mq [$];
  logic [17:0]      exp_q [$];
  cmd_t             cur = '0;
  int               phase = -1;
  logic             m_rv = 1'b0;
  logic [W-1:0]     m_res = '0;
  logic [1:0]       m_cls = '0;
  bit               acc, take, ld;
  cmd_t             nc;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      exp_q.delete();
      cur   = '0;
      phase = -1;
      m_rv  = 1'b0;
      m_res = '0;
      m_cls = '0;
    end else begin
      acc  = bus1.CMD_VALID && (mq.size() != D);
      take = m_rv && bus1.RES_READY;
      ld   = ((phase == -1) || take) && (mq.size() != 0);
      nc   = {bus1.CMD_A, bus1.CMD_B, bus1.CMD_FUN};
      if (take) m_rv = 1'b0;
      if (ld) begin
        cur   = mq.pop_front();
        phase = 0;
      end else if (take) begin
        phase = -1;
      end else if (phase >= 0 && phase <= LAT) begin
        phase++;
        if (phase == LAT + 1) begin
          m_rv  = 1'b1;
          m_res = alu_fn(cur);
          m_cls = cur.fun[3:2];
        end
      end
      if (acc) begin
        mq.push_back(nc);
        exp_q.push_back({nc.fun[3:2], alu_fn(nc)});
      end
    end
  end

  bit          chk_en = 1'b0;
  logic [17:0] hs_q [$];
  int          hs_cyc [$];
  int          rv_cnt = 0, go1_cnt = 0, go3_cnt = 0;

  always @(negedge clk) begin
    if (bus1.ALU_GO === 1'b1) go1_cnt++;
    if (bus3.ALU_GO === 1'b1) go3_cnt++;
    if (bus1.RES_VALID === 1'b1) rv_cnt++;
    if (chk_en) begin
      chk("cmd_ready", 32'(bus1.CMD_READY), 32'(mq.size() != D));
      chk("fifo_count", 32'(bus1.FIFO_COUNT), 32'(mq.size()));
      chk("alu_go", 32'(bus1.ALU_GO), 32'(phase == 0));
      chk("alu_a", 32'(bus1.ALU_A), 32'(cur.a));
      chk("alu_b", 32'(bus1.ALU_B), 32'(cur.b));
      chk("alu_fun", 32'(bus1.ALU_FUN), 32'(cur.fun));
      chk("res_valid", 32'(bus1.RES_VALID), 32'(m_rv));
      if (m_rv) begin
        chk("res_data", 32'(bus1.RES_DATA), 32'(m_res));
        chk("res_class", 32'(bus1.RES_CLASS), 32'(m_cls));
      end
      if (bus1.RES_VALID === 1'b1 && bus1.RES_READY === 1'b1) begin
        hs_q.push_back({bus1.RES_CLASS, bus1.RES_DATA});
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("sb_unexpected", 32'(bus1.RES_DATA), 32'hFFFF_FFFF);
        else chk("sb_order", 32'({bus1.RES_CLASS, bus1.RES_DATA}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun);
    logic r;
    int   n;
    bus1.CMD_VALID = 1'b1;
    bus1.CMD_A     = a;
    bus1.CMD_B     = b;
    bus1.CMD_FUN   = fun;
    r = 1'b0;
    n = 0;
    while (!r && n < 100) begin
      @(negedge clk);
      r = bus1.CMD_READY;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", 32'(r), 32'd1);
    bus1.CMD_VALID = 1'b0;
  endtask

  logic [W-1:0] t2_d [4];
  int           n;
  bit           gs;

  initial begin
    t2_d = '{16'h2143, 16'h000F, 16'h0001, 16'h0010};
    bus1.CMD_VALID = 1'b0; bus1.CMD_A = '0; bus1.CMD_B = '0; bus1.CMD_FUN = '0;
    bus1.RES_READY = 1'b0;
    bus3.CMD_VALID = 1'b0; bus3.CMD_A = '0; bus3.CMD_B = '0; bus3.CMD_FUN = '0;
    bus3.RES_READY = 1'b1;

    // Reset state
    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    chk("rst_cmd_ready", 32'(bus1.CMD_READY), 32'd1);
    chk("rst_count", 32'(bus1.FIFO_COUNT), 32'd0);
    chk("rst_res_valid", 32'(bus1.RES_VALID), 32'd0);
    chk("rst_alu_go", 32'(bus1.ALU_GO), 32'd0);
    chk("rst_alu_a", 32'(bus1.ALU_A), 32'd0);
    rst = 1'b0;
    go1_cnt = 0;

    // Single command: 5 + 3
    bus1.RES_READY = 1'b1;
    send(16'h0005, 16'h0003, 4'b0000);
    n = 0;
    while (bus1.RES_VALID !== 1'b1 && n < 50) begin tick(1); n++; end
    chk("t1_latency", 32'(n), 32'd3);
    chk("t1_data", 32'(bus1.RES_DATA), 32'h0008);
    chk("t1_class", 32'(bus1.RES_CLASS), 32'd0);
    tick(1);
    chk("t1_rv_drop", 32'(bus1.RES_VALID), 32'd0);
    chk("t1_count", 32'(bus1.FIFO_COUNT), 32'd0);
    chk("t1_go_once", 32'(go1_cnt), 32'd1);

    // Four classes back to back
    tick(3);
    hs_q.delete(); hs_cyc.delete();
    send(16'h1234, 16'h0F0F, 4'b0000);
    send(16'h00FF, 16'h0F0F, 4'b0100);
    send(16'h0003, 16'h0007, 4'b1000);
    send(16'h0001, 16'h0004, 4'b1100);
    tick(20);
    chk("t2_count", 32'(hs_q.size()), 32'd4);
    for (int i = 0; i < hs_q.size() && i < 4; i++) begin
      chk("t2_data", 32'(hs_q[i][15:0]), 32'(t2_d[i]));
      chk("t2_class", 32'(hs_q[i][17:16]), 32'(i));
      if (i > 0) chk("t2_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
    end

    // Backpressure: fill the FIFO behind a held result, then stall one more
    hs_q.delete(); hs_cyc.delete();
    bus1.RES_READY = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h0100 + W'(i), 16'h0001, 4'b0000);
    tick(3);
    chk("t3_full_count", 32'(bus1.FIFO_COUNT), 32'd4);
    chk("t3_full_ready", 32'(bus1.CMD_READY), 32'd0);
    chk("t3_hold_valid", 32'(bus1.RES_VALID), 32'd1);
    chk("t3_hold_data", 32'(bus1.RES_DATA), 32'h0101);
    bus1.CMD_VALID = 1'b1; bus1.CMD_A = 16'h0105; bus1.CMD_B = 16'h0001; bus1.CMD_FUN = 4'b0000;
    tick(3);
    chk("t3_stall_count", 32'(bus1.FIFO_COUNT), 32'd4);
    chk("t3_hold_stable", 32'(bus1.RES_DATA), 32'h0101);
    bus1.RES_READY = 1'b1;
    send(16'h0105, 16'h0001, 4'b0000);
    tick(30);
    chk("t3_results", 32'(hs_q.size()), 32'd6);
    for (int i = 0; i < hs_q.size() && i < 6; i++)
      chk("t3_order", 32'(hs_q[i][15:0]), 32'h0101 + 32'(i));

    // Simultaneous write and pop at count 1, then enough pushes to wrap pointers
    hs_q.delete(); hs_cyc.delete();
    send(16'h0020, 16'h0002, 4'b0001);
    send(16'h00F0, 16'h0F00, 4'b0101);
    chk("t4_wr_pop_count", 32'(bus1.FIFO_COUNT), 32'd1);
    for (int i = 0; i < 7; i++)
      send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
    tick(40);
    chk("t4_results", 32'(hs_q.size()), 32'd9);
    chk("t4_first", 32'(hs_q[0]), 32'h0001E);
    chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset while waiting on the ALU with two commands queued
    send(16'h1111, 16'h0001, 4'b0000);
    send(16'h2222, 16'h0001, 4'b0000);
    send(16'h3333, 16'h0001, 4'b0000);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_count", 32'(bus1.FIFO_COUNT), 32'd0);
    chk("t5_cmd_ready", 32'(bus1.CMD_READY), 32'd1);
    chk("t5_res_valid", 32'(bus1.RES_VALID), 32'd0);
    chk("t5_alu_go", 32'(bus1.ALU_GO), 32'd0);
    chk("t5_alu_a", 32'(bus1.ALU_A), 32'd0);
    chk("t5_alu_fun", 32'(bus1.ALU_FUN), 32'd0);
    chk("t5_res_data", 32'(bus1.RES_DATA), 32'd0);
    rv_cnt = 0;
    tick(12);
    chk("t5_no_result", 32'(rv_cnt), 32'd0);

    // ALU_LAT=3 instance
    go3_cnt = 0;
    bus3.CMD_A = 16'h0ABC; bus3.CMD_B = 16'h0123; bus3.CMD_FUN = 4'b0001;
    bus3.CMD_VALID = 1'b1;
    tick(1);
    bus3.CMD_VALID = 1'b0;
    n  = 0;
    gs = 1'b0;
    while (bus3.RES_VALID !== 1'b1 && n < 50) begin
      tick(1);
      n++;
      if (bus3.ALU_GO === 1'b1) gs = 1'b1;
      if (gs) begin
        chk("t6_alu_a", 32'(bus3.ALU_A), 32'h0ABC);
        chk("t6_alu_b", 32'(bus3.ALU_B), 32'h0123);
        chk("t6_alu_fun", 32'(bus3.ALU_FUN), 32'h1);
      end
    end
    chk("t6_latency", 32'(n), 32'd5);
    chk("t6_data", 32'(bus3.RES_DATA), 32'h0999);
    chk("t6_class", 32'(bus3.RES_CLASS), 32'd0);
    tick(3);
    chk("t6_go_once", 32'(go3_cnt), 32'd1);
    chk("t6_rv_drop", 32'(bus3.RES_VALID), 32'd0);
    chk("t6_count", 32'(bus3.FIFO_COUNT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
